ibex_alu_arbiter: RTL and testbench
===================================

// Module: ibex_alu_arbiter
// PURPOSE
// - Shares one ibex_alu between NumReq requesters, e.g. the ID/EX pipeline and an auxiliary
//   address or checker unit. Each requester has a valid/ready request channel.
// - Selects one request per cycle and drives it onto the ALU's combinational inputs.
// - Registers the ALU result and returns it on a single valid/ready response channel,
//   tagged with the requester index. Sits between the requesters and the ALU instance.
// PARAMETERS
// - NumReq  2  number of requesters; legal range 2..4.
// - IdW     $clog2(NumReq)  width of the response tag (derived, do not override).
// PORTS
// - clk_i                    in   1            clock
// - rst_ni                   in   1            asynchronous active-low reset
// - req_valid_i              in   NumReq       per-requester request valid
// - req_ready_o              out  NumReq       per-requester accept; at most one bit high per cycle
// - req_operator_i           in   NumReq x alu_op_e  per-requester ALU operation
// - req_operand_a_i          in   NumReq x 32  per-requester operand A
// - req_operand_b_i          in   NumReq x 32  per-requester operand B
// - rsp_valid_o              out  1            registered response valid
// - rsp_ready_i              in   1            response consumer ready
// - rsp_id_o                 out  IdW          index of the requester that owns the response
// - rsp_result_o             out  32           captured ALU result_o
// - rsp_cmp_o                out  1            captured ALU comparison_result_o
// - alu_operator_o           out  alu_op_e     to ALU operator_i
// - alu_operand_a_o          out  32           to ALU operand_a_i
// - alu_operand_b_o          out  32           to ALU operand_b_i
// - alu_multdiv_sel_o        out  1            to ALU multdiv_sel_i; tied to 0
// - alu_result_i             in   32           from ALU result_o
// - alu_comparison_result_i  in   1            from ALU comparison_result_o
// BEHAVIOUR
// - Reset values: rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, rsp_cmp_o=0, rr_ptr=0, state=EMPTY.
// - Response register FSM:
//   - EMPTY->FULL on accept.
//   - FULL->FULL on accept && rsp_ready_i.
//   - FULL->EMPTY on rsp_ready_i && !accept.
//   - FULL holds otherwise, with rsp_* stable.
// - can_accept = (state==EMPTY) | rsp_ready_i. Throughput is 1 op/cycle when back-to-back.
// - Grant (round-robin): first valid requester at or after rr_ptr, modulo NumReq.
//   - req_ready_o[g] = can_accept & req_valid_i[g].
//   - accept = |req_ready_o.
//   - On accept: rr_ptr <= (g+1) mod NumReq.
// - req_ready_o depends combinationally on req_valid_i. Requesters must not make valid depend on ready.
// - Once raised, a requester holds valid and its payload stable until accepted (bench asserts this).
// - ALU mux follows the granted requester; with no valid request it selects requester rr_ptr.
//   The ALU is stateless, so idle muxing has no side effects.
// - Latency: request accepted in cycle N -> rsp_valid_o=1 in N+1, carrying rsp_id_o=g and
//   rsp_result_o/rsp_cmp_o sampled from the ALU in cycle N.
// - rsp_cmp_o is captured for every op; consumers use it only for comparison operators.
// - Fairness: a continuously valid requester is granted within NumReq accepts.
// - rsp_ready_i low while FULL: all req_ready_o=0 and the response is held with no data change.
// - rsp_ready_i high with no accept: response retires, rsp_valid_o=0 next cycle.
// - Reset asserted mid-operation: pending response is dropped with no retirement pulse.
//   Requesters re-issue any in-flight op.
// - rr_ptr wraps NumReq-1 -> 0. Non-power-of-2 NumReq never produces an out-of-range index.
// CONFIGURATION
// - IBEX_ALU_ARB_FIXED_PRIO_EN defined:
//   - Fixed priority, lowest index wins; rr_ptr is removed.
//   - Fairness bound is void; requester 0 can starve the others.
// - Undefined (default): round-robin as described above.
// TESTING
// - Reset, then req0 valid ADD a=5 b=7 -> ready0=1 same cycle; next cycle rsp_valid=1, id=0, result=12.
// - req0 and req1 both valid continuously, rsp_ready=1, after reset -> grants 0,1,0,1;
//   one response per cycle. With FIXED_PRIO_EN -> grants 0,0,0,...
// - req1 SLTU a=1 b=0xFFFFFFFF, rsp_ready=0 for 3 cycles -> result=1, cmp=1 held stable,
//   ready_o=0 throughout; retires on rsp_ready=1.
// - FULL with rsp_ready=1 and req0 SUB a=3 b=5 valid -> accepted same cycle;
//   next rsp result=0xFFFFFFFE, rsp_valid stays 1.
// - rst_ni low while FULL -> rsp_valid_o=0 immediately; after release rr_ptr=0 and req0 is granted first.
// - NumReq=3, only req2 valid -> granted; rr_ptr wraps to 0; alu_multdiv_sel_o=0 at all times.

Source files
------------

// File: rtl/ibex_alu_arbiter.sv
// rtl/ibex_alu_arbiter.sv - Shares one combinational ALU between NumReq valid/ready requesters.
// Define IBEX_ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.

package ibex_alu_arb_pkg;
   typedef enum logic [6:0] {
      ALU_ADD  = 7'd0,
      ALU_SUB  = 7'd1,
      ALU_XOR  = 7'd2,
      ALU_OR   = 7'd3,
      ALU_AND  = 7'd4,
      ALU_SLT  = 7'd5,
      ALU_SLTU = 7'd6,
      ALU_EQ   = 7'd7
   } alu_op_e;
endpackage

module ibex_alu_arbiter
   import ibex_alu_arb_pkg::*;
#(
   parameter int unsigned NumReq = 2,
   parameter int unsigned IdW    = $clog2(NumReq)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NumReq-1:0]        req_valid_i,
   output logic [NumReq-1:0]        req_ready_o,
   input  alu_op_e [NumReq-1:0]     req_operator_i,
   input  logic [NumReq-1:0][31:0]  req_operand_a_i,
   input  logic [NumReq-1:0][31:0]  req_operand_b_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [IdW-1:0]           rsp_id_o,
   output logic [31:0]              rsp_result_o,
   output logic                     rsp_cmp_o,
   output alu_op_e                  alu_operator_o,
   output logic [31:0]              alu_operand_a_o,
   output logic [31:0]              alu_operand_b_o,
   output logic                     alu_multdiv_sel_o,
   input  logic [31:0]              alu_result_i,
   input  logic                     alu_comparison_result_i
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [IdW-1:0] gnt_idx;
   logic           gnt_found;
   logic           can_accept;
   logic           accept;

   logic [IdW-1:0] rsp_id_q, rsp_id_d;
   logic [31:0]    rsp_result_q, rsp_result_d;
   logic           rsp_cmp_q, rsp_cmp_d;

`ifdef IBEX_ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         if (!gnt_found && req_valid_i[k]) begin
            gnt_found = 1'b1;
            gnt_idx   = IdW'(k);
         end
      end
   end
`else
   logic [IdW-1:0] rr_ptr_q, rr_ptr_d;

   // Search starts at rr_ptr and wraps explicitly so non-power-of-2 NumReq stays in range.
   always_comb begin
      int unsigned    idx;
      logic [IdW-1:0] idx_n;
      gnt_found = 1'b0;
      gnt_idx   = rr_ptr_q;
      idx       = 0;
      idx_n     = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= NumReq) begin
            idx = idx - NumReq;
         end
         idx_n = IdW'(idx);
         if (!gnt_found && req_valid_i[idx_n]) begin
            gnt_found = 1'b1;
            gnt_idx   = idx_n;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (gnt_idx == IdW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   assign can_accept = (state_q == EMPTY) | rsp_ready_i;
   assign accept     = can_accept & gnt_found;

   always_comb begin
      req_ready_o = '0;
      if (accept) begin
         req_ready_o[gnt_idx] = 1'b1;
      end
   end

   // With no request the mux parks on the default index; the ALU is stateless.
   assign alu_operator_o    = req_operator_i[gnt_idx];
   assign alu_operand_a_o   = req_operand_a_i[gnt_idx];
   assign alu_operand_b_o   = req_operand_b_i[gnt_idx];
   assign alu_multdiv_sel_o = 1'b0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (rsp_ready_i && !accept) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_cmp_d    = rsp_cmp_q;
      if (accept) begin
         rsp_id_d     = gnt_idx;
         rsp_result_d = alu_result_i;
         rsp_cmp_d    = alu_comparison_result_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= EMPTY;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_cmp_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_cmp_q    <= rsp_cmp_d;
      end
   end

   assign rsp_valid_o  = (state_q == FULL);
   assign rsp_id_o     = rsp_id_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_cmp_o    = rsp_cmp_q;

endmodule

// File: tb/tb_ibex_alu_arbiter.sv
// tb/tb_ibex_alu_arbiter.sv - Directed and randomized checks of ibex_alu_arbiter with NumReq=3.
`timescale 1ns/1ps

module tb_ibex_alu_arbiter;
   import ibex_alu_arb_pkg::*;

   localparam int NR  = 3;
   localparam int IDW = $clog2(NR);

   logic                 clk;
   logic                 rst_n;
   logic [NR-1:0]        req_valid;
   logic [NR-1:0]        req_ready;
   alu_op_e [NR-1:0]     req_op;
   logic [NR-1:0][31:0]  req_a;
   logic [NR-1:0][31:0]  req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [31:0]          rsp_result;
   logic                 rsp_cmp;
   alu_op_e              alu_op;
   logic [31:0]          alu_a;
   logic [31:0]          alu_b;
   logic                 alu_multdiv;
   logic [31:0]          alu_res;
   logic                 alu_cmp;

   int n_checks = 0;
   int n_errors = 0;

   bit          m_full;
   int          m_ptr;
   int          m_id;
   logic [31:0] m_res;
   logic        m_cmp;
   int          last_gnt;

   ibex_alu_arbiter #(.NumReq(NR)) dut (
      .clk_i                   (clk),
      .rst_ni                  (rst_n),
      .req_valid_i             (req_valid),
      .req_ready_o             (req_ready),
      .req_operator_i          (req_op),
      .req_operand_a_i         (req_a),
      .req_operand_b_i         (req_b),
      .rsp_valid_o             (rsp_valid),
      .rsp_ready_i             (rsp_ready),
      .rsp_id_o                (rsp_id),
      .rsp_result_o            (rsp_result),
      .rsp_cmp_o               (rsp_cmp),
      .alu_operator_o          (alu_op),
      .alu_operand_a_o         (alu_a),
      .alu_operand_b_o         (alu_b),
      .alu_multdiv_sel_o       (alu_multdiv),
      .alu_result_i            (alu_res),
      .alu_comparison_result_i (alu_cmp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [32:0] alu_fn(input alu_op_e op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [31:0] r;
      logic        c;
      c = (a == b);
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_XOR:  r = a ^ b;
         ALU_OR:   r = a | b;
         ALU_AND:  r = a & b;
         ALU_SLT:  begin c = ($signed(a) < $signed(b)); r = {31'b0, c}; end
         ALU_SLTU: begin c = (a < b); r = {31'b0, c}; end
         default:  r = {31'b0, c};
      endcase
      return {c, r};
   endfunction

   always_comb {alu_cmp, alu_res} = alu_fn(alu_op, alu_a, alu_b);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_full = 1'b0;
      m_ptr  = 0;
      m_id   = 0;
      m_res  = '0;
      m_cmp  = 1'b0;
   endtask

   task automatic set_req(input int i, input alu_op_e op, input logic [31:0] a,
                          input logic [31:0] b);
      req_valid[i] = 1'b1;
      req_op[i]    = op;
      req_a[i]     = a;
      req_b[i]     = b;
   endtask

   // Called just after a falling edge with inputs applied; returns just after the next falling edge.
   task automatic step();
      int            g;
      bit            can;
      logic [NR-1:0] exp_rdy;
      #1;
      can = !m_full || rsp_ready;
      g   = -1;
      for (int k = 0; k < NR; k++) begin
         int i;
`ifdef IBEX_ALU_ARB_FIXED_PRIO_EN
         i = k;
`else
         i = (m_ptr + k) % NR;
`endif
         if (g < 0 && req_valid[i]) g = i;
      end
      exp_rdy = '0;
      if (can && g >= 0) exp_rdy[g] = 1'b1;
      check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(m_full));
      if (m_full) begin
         check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
         check_eq("rsp_result", rsp_result, m_res);
         check_eq("rsp_cmp", 32'(rsp_cmp), 32'(m_cmp));
      end
      check_eq("multdiv_sel", 32'(alu_multdiv), 32'd0);
      last_gnt = (can && g >= 0) ? g : -1;
      if (last_gnt >= 0) begin
         m_full = 1'b1;
         m_id   = g;
         {m_cmp, m_res} = alu_fn(req_op[g], req_a[g], req_b[g]);
         m_ptr  = (g + 1) % NR;
      end else if (rsp_ready) begin
         m_full = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      #1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int exp_seq[4];

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NR; i++) begin
         req_op[i] = ALU_ADD;
         req_a[i]  = '0;
         req_b[i]  = '0;
      end
      model_reset();
      last_gnt = -1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("reset_rsp_id", 32'(rsp_id), 32'd0);
      check_eq("reset_rsp_result", rsp_result, 32'd0);
      check_eq("reset_rsp_cmp", 32'(rsp_cmp), 32'd0);
      rst_n = 1'b1;

      // Single ADD with one-cycle response latency.
      rsp_ready = 1'b1;
      set_req(0, ALU_ADD, 32'd5, 32'd7);
      step();
      check_eq("add_gnt", 32'(last_gnt), 32'd0);
      check_eq("add_valid", 32'(rsp_valid), 32'd1);
      check_eq("add_id", 32'(rsp_id), 32'd0);
      check_eq("add_result", rsp_result, 32'd12);
      step();
      check_eq("retire_valid", 32'(rsp_valid), 32'd0);

      // Two continuously valid requesters.
      do_reset();
`ifdef IBEX_ALU_ARB_FIXED_PRIO_EN
      exp_seq = '{0, 0, 0, 0};
`else
      exp_seq = '{0, 1, 0, 1};
`endif
      for (int n = 0; n < 4; n++) begin
         set_req(0, ALU_ADD, 32'(n), 32'd100);
         set_req(1, ALU_XOR, 32'(n), 32'hFF);
         step();
         check_eq("rr_gnt", 32'(last_gnt), 32'(exp_seq[n]));
         check_eq("rr_rsp_valid", 32'(rsp_valid), 32'd1);
      end
      req_valid = '0;
      step();

      // SLTU response held under backpressure, then replaced by a SUB.
      rsp_ready = 1'b0;
      set_req(1, ALU_SLTU, 32'd1, 32'hFFFF_FFFF);
      step();
      set_req(0, ALU_SUB, 32'd3, 32'd5);
      for (int n = 0; n < 3; n++) begin
         step();
         check_eq("hold_result", rsp_result, 32'd1);
         check_eq("hold_cmp", 32'(rsp_cmp), 32'd1);
         check_eq("hold_id", 32'(rsp_id), 32'd1);
      end
      rsp_ready = 1'b1;
      step();
      check_eq("sub_valid", 32'(rsp_valid), 32'd1);
      check_eq("sub_result", rsp_result, 32'hFFFF_FFFE);
      step();
      check_eq("sub_retire", 32'(rsp_valid), 32'd0);

      // Asynchronous reset while FULL drops the response immediately.
      set_req(0, ALU_ADD, 32'd1, 32'd1);
      rsp_ready = 1'b0;
      step();
      check_eq("pre_rst_valid", 32'(rsp_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_valid", 32'(rsp_valid), 32'd0);
      req_valid = '0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      set_req(0, ALU_OR, 32'hF0, 32'h0F);
      set_req(1, ALU_AND, 32'hF0, 32'h3C);
      step();
      check_eq("post_rst_gnt", 32'(last_gnt), 32'd0);
      req_valid = '0;

      // Highest index alone, then pointer wrap back to 0.
      set_req(2, ALU_EQ, 32'd9, 32'd9);
      step();
      check_eq("req2_gnt", 32'(last_gnt), 32'd2);
      check_eq("req2_id", 32'(rsp_id), 32'd2);
      check_eq("req2_cmp", 32'(rsp_cmp), 32'd1);
      set_req(0, ALU_ADD, 32'd2, 32'd2);
      set_req(1, ALU_ADD, 32'd3, 32'd3);
      set_req(2, ALU_ADD, 32'd4, 32'd4);
      step();
      check_eq("wrap_gnt", 32'(last_gnt), 32'd0);
      req_valid = '0;
      step();

      // Randomized traffic against the reference model.
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] && ($urandom_range(0, 2) != 0)) begin
               set_req(i, alu_op_e'(7'($urandom_range(0, 7))), $urandom, 
                       ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (n % 150 == 149) begin
            do_reset();
         end else begin
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
